// File: rtl/mopshub_rec_arb_pkg.sv
// -----------------------------------------------------------------------------
// mopshub_rec_arb_pkg
// Shared definitions for the MOPSHUB receive arbiter:
//   rec_arb_state_t : arbiter FSM state encoding (IDLE -> LATCH -> SEND)
//   FRAME_W         : width of one decoded CAN frame (id + dlc + payload)
//   DROP_CNT_W      : width of the saturating timeout drop counter
//   sat_inc_drop    : saturating increment used by the drop counter
// -----------------------------------------------------------------------------
package mopshub_rec_arb_pkg;

   localparam int FRAME_W    = 76;
   localparam int DROP_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LATCH = 2'd1,
      SEND  = 2'd2
   } rec_arb_state_t;

   // Holds at all-ones instead of wrapping back to zero.
   function automatic logic [DROP_CNT_W-1:0] sat_inc_drop(input logic [DROP_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/mopshub_rec_arbiter_rr_next_index.sv
// -----------------------------------------------------------------------------
// rr_next_index
// Combinational masked round-robin finder.
//   mask    : in  N_BUS  candidate requests (bits above n_buses already cleared)
//   last    : in  SEL_W  index granted most recently
//   n_buses : in  SEL_W  highest enabled bus index
//   found   : out 1      at least one mask bit is set
//   index   : out SEL_W  first set bit in last+1..n_buses, else first in 0..last
// When last lies at or above n_buses the search simply starts at bus 0.
// -----------------------------------------------------------------------------
module rr_next_index #(
   parameter  int N_BUS = 32,
   localparam int SEL_W = $clog2(N_BUS)
) (
   input  logic [N_BUS-1:0] mask,
   input  logic [SEL_W-1:0] last,
   input  logic [SEL_W-1:0] n_buses,
   output logic             found,
   output logic [SEL_W-1:0] index
);

   // One extra bit so last+1 cannot wrap to zero when last = N_BUS-1.
   logic [SEL_W:0]   start;
   logic             hi_found;
   logic [SEL_W-1:0] hi_idx;
   logic             lo_found;
   logic [SEL_W-1:0] lo_idx;

   always_comb begin
      start    = (last >= n_buses) ? '0 : ({1'b0, last} + 1'b1);
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_found = 1'b0;
      lo_idx   = '0;
      // Walk downward so the last hit is the lowest set index.
      // hi_* : lowest set bit at or above start; lo_* : lowest set bit overall.
      for (int i = N_BUS - 1; i >= 0; i--) begin
         if (mask[i]) begin
            lo_found = 1'b1;
            lo_idx   = SEL_W'(i);
            if ((SEL_W+1)'(i) >= start) begin
               hi_found = 1'b1;
               hi_idx   = SEL_W'(i);
            end
         end
      end
      found = lo_found;
      index = hi_found ? hi_idx : lo_idx;
   end

endmodule

// File: rtl/mopshub_rec_arbiter.sv
// -----------------------------------------------------------------------------
// mopshub_rec_arbiter
// Round-robin collector of received CAN frames from N_BUS channels onto a
// single DATA_W-bit uplink toward the e-link transmitter.
//
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   n_buses          : highest enabled bus index (sampled only in IDLE)
//   irq_can_rec      : per-bus level request, held until acked
//   data_rec_in      : flattened frames, bus i at [i*DATA_W +: DATA_W]
//   can_rec_ack      : one-hot single-cycle pulse, frame of that bus latched
//   can_rec_select   : index of the bus currently granted
//   data_rec_uplink  : latched frame
//   irq_elink_rec    : uplink valid
//   uplink_rdy       : uplink ready
//   frames_sent      : wrapping count of accepted uplink transfers
//   drop_cnt         : saturating count of timeout drops
//   drop_err         : single-cycle pulse per timeout drop
//
// Uplink handshake: irq_elink_rec (valid) and data_rec_uplink stay stable
// from the LATCH->SEND edge until a rising clock edge with
// irq_elink_rec && uplink_rdy; that edge is the transfer. uplink_rdy may be
// high before valid and is ignored outside SEND.
//
// Build option MOPSHUB_REC_TIMEOUT_EN: when defined, a frame that waits
// TIMEOUT cycles in SEND without a transfer is dropped (drop_err pulse,
// drop_cnt increment). When undefined SEND waits indefinitely and
// drop_cnt / drop_err are constant 0.
// -----------------------------------------------------------------------------
module mopshub_rec_arbiter
   import mopshub_rec_arb_pkg::*;
#(
   parameter  int N_BUS   = 32,
   parameter  int DATA_W  = FRAME_W,
   parameter  int TIMEOUT = 1024,
   localparam int SEL_W   = $clog2(N_BUS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [SEL_W-1:0]        n_buses,
   input  logic [N_BUS-1:0]        irq_can_rec,
   input  logic [N_BUS*DATA_W-1:0] data_rec_in,
   output logic [N_BUS-1:0]        can_rec_ack,
   output logic [SEL_W-1:0]        can_rec_select,
   output logic [DATA_W-1:0]       data_rec_uplink,
   output logic                    irq_elink_rec,
   input  logic                    uplink_rdy,
   output logic [15:0]             frames_sent,
   output logic [DROP_CNT_W-1:0]   drop_cnt,
   output logic                    drop_err
);

   rec_arb_state_t    state_q,  state_d;
   logic [SEL_W-1:0]  last_q,   last_d;
   logic [SEL_W-1:0]  sel_q,    sel_d;
   logic [DATA_W-1:0] data_q,   data_d;
   logic              valid_q,  valid_d;
   logic [N_BUS-1:0]  ack_q,    ack_d;
   logic [15:0]       frames_q, frames_d;

`ifdef MOPSHUB_REC_TIMEOUT_EN
   localparam int TMR_W = 1 + $clog2(TIMEOUT);

   logic [TMR_W-1:0]      timer_q,    timer_d;
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic                  drop_err_q, drop_err_d;
`endif

   // Requests from buses above n_buses never take part in arbitration.
   logic [N_BUS-1:0] req_mask;
   logic             rr_found;
   logic [SEL_W-1:0] rr_index;

   always_comb begin
      req_mask = '0;
      for (int i = 0; i < N_BUS; i++) begin
         req_mask[i] = irq_can_rec[i] && (SEL_W'(i) <= n_buses);
      end
   end

   rr_next_index #(
      .N_BUS   (N_BUS)
   ) u_rr_next_index (
      .mask    (req_mask),
      .last    (last_q),
      .n_buses (n_buses),
      .found   (rr_found),
      .index   (rr_index)
   );

   // Next-state logic for the whole arbiter.
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      sel_d    = sel_q;
      data_d   = data_q;
      valid_d  = valid_q;
      ack_d    = '0;
      frames_d = frames_q;
`ifdef MOPSHUB_REC_TIMEOUT_EN
      timer_d    = timer_q;
      drop_cnt_d = drop_cnt_q;
      drop_err_d = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            if (rr_found) begin
               sel_d   = rr_index;
               state_d = LATCH;
            end
         end

         LATCH: begin
            data_d  = data_rec_in[sel_q*DATA_W +: DATA_W];
            ack_d   = N_BUS'(1) << sel_q;
            last_d  = sel_q;
            valid_d = 1'b1;
            state_d = SEND;
`ifdef MOPSHUB_REC_TIMEOUT_EN
            timer_d = '0;
`endif
         end

         SEND: begin
            // A transfer on the same edge takes priority over the timeout.
            if (valid_q && uplink_rdy) begin
               valid_d  = 1'b0;
               frames_d = frames_q + 16'd1;
               state_d  = IDLE;
            end
`ifdef MOPSHUB_REC_TIMEOUT_EN
            else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
               valid_d    = 1'b0;
               drop_err_d = 1'b1;
               drop_cnt_d = sat_inc_drop(drop_cnt_q);
               state_d    = IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
`endif
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         last_q   <= SEL_W'(N_BUS - 1);   // bus 0 wins the first arbitration
         sel_q    <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         ack_q    <= '0;
         frames_q <= '0;
`ifdef MOPSHUB_REC_TIMEOUT_EN
         timer_q    <= '0;
         drop_cnt_q <= '0;
         drop_err_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         sel_q    <= sel_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         ack_q    <= ack_d;
         frames_q <= frames_d;
`ifdef MOPSHUB_REC_TIMEOUT_EN
         timer_q    <= timer_d;
         drop_cnt_q <= drop_cnt_d;
         drop_err_q <= drop_err_d;
`endif
      end
   end

   assign can_rec_ack     = ack_q;
   assign can_rec_select  = sel_q;
   assign data_rec_uplink = data_q;
   assign irq_elink_rec   = valid_q;
   assign frames_sent     = frames_q;

`ifdef MOPSHUB_REC_TIMEOUT_EN
   assign drop_cnt = drop_cnt_q;
   assign drop_err = drop_err_q;
`else
   // No timeout hardware: both are constant 0 for any legal TIMEOUT.
   assign drop_cnt = '0;
   assign drop_err = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_mopshub_rec_arbiter.sv
module tb_mopshub_rec_arbiter;

   localparam int N_BUS  = 32;
   localparam int DATA_W = 76;
   localparam int SEL_W  = 5;
`ifdef MOPSHUB_REC_TIMEOUT_EN
   localparam int STALL  = 10;
`else
   localparam int STALL  = 50;
`endif

   logic                    clk;
   logic                    rst;
   logic [SEL_W-1:0]        n_buses;
   logic [N_BUS-1:0]        irq_can_rec;
   logic [N_BUS*DATA_W-1:0] data_rec_in;
   logic [N_BUS-1:0]        can_rec_ack;
   logic [SEL_W-1:0]        can_rec_select;
   logic [DATA_W-1:0]       data_rec_uplink;
   logic                    irq_elink_rec;
   logic                    uplink_rdy;
   logic [15:0]             frames_sent;
   logic [7:0]              drop_cnt;
   logic                    drop_err;

   int n_checks = 0;
   int n_fail   = 0;

   mopshub_rec_arbiter #(
      .N_BUS   (N_BUS),
      .DATA_W  (DATA_W),
      .TIMEOUT (16)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .n_buses         (n_buses),
      .irq_can_rec     (irq_can_rec),
      .data_rec_in     (data_rec_in),
      .can_rec_ack     (can_rec_ack),
      .can_rec_select  (can_rec_select),
      .data_rec_uplink (data_rec_uplink),
      .irq_elink_rec   (irq_elink_rec),
      .uplink_rdy      (uplink_rdy),
      .frames_sent     (frames_sent),
      .drop_cnt        (drop_cnt),
      .drop_err        (drop_err)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   function automatic logic [DATA_W-1:0] frame_of(input int i);
      logic [DATA_W-1:0] f;
      if (i == 0) f = 76'h5A5;
      else        f = {12'(i), 64'hF00D_BEEF_0000_0000 | 64'(i)};
      return f;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until an ack pulse is seen; cycles = -1 when the budget expires.
   task automatic wait_ack(input int budget, output int cycles);
      cycles = 0;
      while (cycles < budget) begin
         tick();
         cycles++;
         if (can_rec_ack != '0) return;
      end
      cycles = -1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      n_checks++;
      if (can_rec_select !== 5'd0 || data_rec_uplink !== '0 || irq_elink_rec !== 1'b0 ||
          can_rec_ack !== '0 || frames_sent !== 16'd0 || drop_cnt !== 8'd0 || drop_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: sel=%0d data=%h valid=%b ack=%h frames=%0d drop_cnt=%0d drop_err=%b, expected all 0",
                  can_rec_select, data_rec_uplink, irq_elink_rec, can_rec_ack, frames_sent, drop_cnt, drop_err);
      end
   endtask

   task automatic test_single();
      uplink_rdy  = 1'b1;            // ready before valid
      irq_can_rec = 32'h1;
      tick();                        // edge k: grant
      n_checks++;
      if (can_rec_select !== 5'd0 || irq_elink_rec !== 1'b0) begin
         n_fail++;
         $display("FAIL single_grant: sel=%0d valid=%b, expected sel=0 valid=0", can_rec_select, irq_elink_rec);
      end
      tick();                        // edge k+1: latch
      n_checks++;
      if (irq_elink_rec !== 1'b1 || data_rec_uplink !== 76'h5A5 || can_rec_ack !== 32'h1) begin
         n_fail++;
         $display("FAIL single_latch: valid=%b data=%h ack=%h, expected 1 5a5 00000001",
                  irq_elink_rec, data_rec_uplink, can_rec_ack);
      end
      irq_can_rec = '0;
      tick();                        // edge k+2: transfer
      n_checks++;
      if (irq_elink_rec !== 1'b0 || can_rec_ack !== '0 || frames_sent !== 16'd1) begin
         n_fail++;
         $display("FAIL single_xfer: valid=%b ack=%h frames=%0d, expected 0 0 1",
                  irq_elink_rec, can_rec_ack, frames_sent);
      end
      tick();
      n_checks++;
      if (irq_elink_rec !== 1'b0 || frames_sent !== 16'd1) begin
         n_fail++;
         $display("FAIL single_idle: valid=%b frames=%0d, expected 0 1", irq_elink_rec, frames_sent);
      end
   endtask

   task automatic test_back_to_back();
      logic [SEL_W-1:0] exp_q[$];
      logic [SEL_W-1:0] exp_sel;
      int c;
      int g;
      exp_q = '{5'd3, 5'd7, 5'd31, 5'd3, 5'd7, 5'd31};
      n_buses     = 5'd31;
      uplink_rdy  = 1'b1;
      irq_can_rec = (32'h1 << 3) | (32'h1 << 7) | (32'h1 << 31);
      g = 0;
      while (exp_q.size() > 0) begin
         exp_sel = exp_q.pop_front();
         wait_ack(12, c);
         n_checks++;
         if (c !== ((g == 0) ? 2 : 3)) begin
            n_fail++;
            $display("FAIL rr_interval[%0d]: cycles=%0d, expected %0d", g, c, (g == 0) ? 2 : 3);
         end
         n_checks++;
         if (can_rec_select !== exp_sel || can_rec_ack !== (32'h1 << exp_sel) ||
             data_rec_uplink !== frame_of(int'(exp_sel)) || irq_elink_rec !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_grant[%0d]: sel=%0d ack=%h data=%h valid=%b, expected sel=%0d",
                     g, can_rec_select, can_rec_ack, data_rec_uplink, irq_elink_rec, exp_sel);
         end
         g++;
      end
      irq_can_rec = '0;
      tick();
      tick();
      n_checks++;
      if (frames_sent !== 16'd7 || irq_elink_rec !== 1'b0) begin
         n_fail++;
         $display("FAIL rr_frames: frames=%0d valid=%b, expected 7 0", frames_sent, irq_elink_rec);
      end
   endtask

   task automatic test_n_buses_limit();
      int c2;
      int c9;
      int cother;
      c2 = 0; c9 = 0; cother = 0;
      n_buses     = 5'd4;
      uplink_rdy  = 1'b1;
      irq_can_rec = (32'h1 << 2) | (32'h1 << 9);
      for (int i = 0; i < 12; i++) begin
         tick();
         if (can_rec_ack[2]) c2++;
         if (can_rec_ack[9]) c9++;
         if ((can_rec_ack & ~((32'h1 << 2) | (32'h1 << 9))) != '0) cother++;
      end
      irq_can_rec = '0;
      n_checks++;
      if (c2 !== 4 || c9 !== 0 || cother !== 0) begin
         n_fail++;
         $display("FAIL nbuses_acks: bus2=%0d bus9=%0d other=%0d, expected 4 0 0", c2, c9, cother);
      end
      tick();
      n_checks++;
      if (frames_sent !== 16'd11 || irq_elink_rec !== 1'b0) begin
         n_fail++;
         $display("FAIL nbuses_frames: frames=%0d valid=%b, expected 11 0", frames_sent, irq_elink_rec);
      end
      n_buses = 5'd31;
   endtask

   task automatic test_stall();
      int c;
      int bad;
      bad = 0;
      uplink_rdy  = 1'b0;
      irq_can_rec = 32'h1 << 5;
      wait_ack(10, c);
      n_checks++;
      if (c !== 2 || can_rec_select !== 5'd5) begin
         n_fail++;
         $display("FAIL stall_grant: cycles=%0d sel=%0d, expected 2 5", c, can_rec_select);
      end
      for (int i = 0; i < STALL; i++) begin
         tick();
         if (irq_elink_rec !== 1'b1 || can_rec_select !== 5'd5 ||
             data_rec_uplink !== frame_of(5) || can_rec_ack !== '0) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL stall_hold: unstable cycles=%0d, expected 0", bad);
      end
      uplink_rdy  = 1'b1;
      irq_can_rec = '0;
      tick();
      n_checks++;
      if (irq_elink_rec !== 1'b0 || frames_sent !== 16'd12 || drop_cnt !== 8'd0 || drop_err !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_xfer: valid=%b frames=%0d drop_cnt=%0d drop_err=%b, expected 0 12 0 0",
                  irq_elink_rec, frames_sent, drop_cnt, drop_err);
      end
      tick();
   endtask

`ifdef MOPSHUB_REC_TIMEOUT_EN
   task automatic test_timeout();
      int c;
      int bad;
      bad = 0;
      uplink_rdy  = 1'b0;
      irq_can_rec = (32'h1 << 1) | (32'h1 << 6);
      wait_ack(10, c);
      n_checks++;
      if (c !== 2 || can_rec_ack !== (32'h1 << 6)) begin
         n_fail++;
         $display("FAIL to_grant: cycles=%0d ack=%h, expected 2 00000040", c, can_rec_ack);
      end
      for (int i = 0; i < 15; i++) begin
         tick();
         if (drop_err !== 1'b0 || irq_elink_rec !== 1'b1) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL to_early: bad cycles=%0d, expected 0", bad);
      end
      tick();
      n_checks++;
      if (drop_err !== 1'b1 || irq_elink_rec !== 1'b0 || drop_cnt !== 8'd1 || frames_sent !== 16'd12) begin
         n_fail++;
         $display("FAIL to_drop: drop_err=%b valid=%b drop_cnt=%0d frames=%0d, expected 1 0 1 12",
                  drop_err, irq_elink_rec, drop_cnt, frames_sent);
      end
      tick();
      n_checks++;
      if (drop_err !== 1'b0 || can_rec_select !== 5'd1) begin
         n_fail++;
         $display("FAIL to_next: drop_err=%b sel=%0d, expected 0 1", drop_err, can_rec_select);
      end
      tick();
      n_checks++;
      if (can_rec_ack !== (32'h1 << 1)) begin
         n_fail++;
         $display("FAIL to_next_ack: ack=%h, expected 00000002", can_rec_ack);
      end
      irq_can_rec = '0;
      uplink_rdy  = 1'b1;
      tick();
      n_checks++;
      if (frames_sent !== 16'd13 || drop_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL to_after: frames=%0d drop_cnt=%0d, expected 13 1", frames_sent, drop_cnt);
      end
      tick();
   endtask
`endif

   task automatic test_reset_mid();
      int c;
      uplink_rdy  = 1'b0;
      irq_can_rec = 32'h1 << 3;
      wait_ack(10, c);
      n_checks++;
      if (c !== 2 || irq_elink_rec !== 1'b1) begin
         n_fail++;
         $display("FAIL rmid_send: cycles=%0d valid=%b, expected 2 1", c, irq_elink_rec);
      end
      rst = 1'b0;
      #1;
      test_reset();
      irq_can_rec = (32'h1 << 0) | (32'h1 << 3);
      tick();
      rst        = 1'b1;
      uplink_rdy = 1'b1;
      tick();
      n_checks++;
      if (can_rec_select !== 5'd0 || irq_elink_rec !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_grant: sel=%0d valid=%b, expected 0 0", can_rec_select, irq_elink_rec);
      end
      tick();
      n_checks++;
      if (can_rec_ack !== 32'h1 || data_rec_uplink !== 76'h5A5) begin
         n_fail++;
         $display("FAIL rmid_ack0: ack=%h data=%h, expected 00000001 5a5", can_rec_ack, data_rec_uplink);
      end
      irq_can_rec = 32'h1 << 3;
      tick();
      tick();
      n_checks++;
      if (can_rec_select !== 5'd3) begin
         n_fail++;
         $display("FAIL rmid_grant3: sel=%0d, expected 3", can_rec_select);
      end
      tick();
      n_checks++;
      if (can_rec_ack !== (32'h1 << 3) || data_rec_uplink !== frame_of(3)) begin
         n_fail++;
         $display("FAIL rmid_ack3: ack=%h data=%h, expected 00000008 %h", can_rec_ack, data_rec_uplink, frame_of(3));
      end
      irq_can_rec = '0;
      tick();
      n_checks++;
      if (frames_sent !== 16'd2 || irq_elink_rec !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_frames: frames=%0d valid=%b, expected 2 0", frames_sent, irq_elink_rec);
      end
   endtask

   // ---------------- sequence ----------------
   initial begin
      rst         = 1'b0;
      n_buses     = 5'd31;
      irq_can_rec = '0;
      uplink_rdy  = 1'b0;
      for (int i = 0; i < N_BUS; i++) data_rec_in[i*DATA_W +: DATA_W] = frame_of(i);
      repeat (3) tick();
      test_reset();
      rst = 1'b1;
      tick();
      test_single();
      test_back_to_back();
      test_n_buses_limit();
      test_stall();
`ifdef MOPSHUB_REC_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/mopshub_rec_arbiter.md
# mopshub_rec_arbiter

Parametrised round-robin arbiter that collects received CAN frames from up to `N_BUS` bus channels and serialises them onto the single 76-bit uplink toward the e-link transmitter. It replaces the fixed 32-bus receive selection in the MOPSHUB core. It adds a runtime-limited bus count, a ready/valid uplink handshake, and an optional stall timeout with a drop counter. It sits between the per-bus CAN receive controllers and the e-link uplink FIFO.

## Interface
Parameters:
- `N_BUS`, 32, number of physical CAN bus channels, 2..64
- `DATA_W`, 76, width of one decoded frame (id + dlc + payload)
- `SEL_W`, `$clog2(N_BUS)`, width of bus index (derived, not overridden)
- `TIMEOUT`, 1024, uplink stall limit in clocks (used only with the macro)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous active-low reset
- `n_buses`  in  SEL_W  highest enabled bus index; buses above it are ignored
- `irq_can_rec`  in  N_BUS  level request per bus; held until acked
- `data_rec_in`  in  N_BUS*DATA_W  flattened frames; bus i at `[i*DATA_W +: DATA_W]`
- `can_rec_ack`  out  N_BUS  one-hot, 1-cycle pulse: frame of that bus latched
- `can_rec_select`  out  SEL_W  index of the bus currently granted
- `data_rec_uplink`  out  DATA_W  latched frame
- `irq_elink_rec`  out  1  uplink valid
- `uplink_rdy`  in  1  uplink ready
- `frames_sent`  out  16  count of accepted uplink transfers, wraps
- `drop_cnt`  out  8  timeouts, saturating (macro only, else tied 0)
- `drop_err`  out  1  1-cycle pulse per timeout drop (macro only, else 0)

## Operation
- FSM states: IDLE, LATCH, SEND.
- IDLE: form mask = `irq_can_rec` with bits > `n_buses` cleared. If mask non-zero, pick first set bit searching `last+1 .. n_buses`, then `0 .. last` (wrap). If `last > n_buses`, search from 0. Register `can_rec_select` and go to LATCH. `n_buses` is sampled only here.
- LATCH: register the selected slice into `data_rec_uplink`, pulse `can_rec_ack[sel]`, set `last = sel`, raise `irq_elink_rec`, go to SEND.
- SEND: hold data and valid stable. On a clock edge with `irq_elink_rec && uplink_rdy`, drop valid, increment `frames_sent`, go to IDLE.
- A bus still requesting after its grant waits its round-robin turn. No bus is granted twice while another enabled bus is requesting.
- Reset values: state IDLE; `last = N_BUS-1` so bus 0 wins first; `can_rec_select = 0`, `data_rec_uplink = 0`, `irq_elink_rec = 0`, `can_rec_ack = 0`, `frames_sent = 0`, `drop_cnt = 0`, `drop_err = 0`.
- Reset asserted mid-transfer: the frame is lost and nothing resumes. The bus controller still holds its request and is re-arbitrated after reset.

## Timing
- Request seen in IDLE at edge k:
  - `can_rec_select` valid after k.
  - Data, ack pulse and `irq_elink_rec` valid after k+1.
- If `uplink_rdy` is already high, the transfer completes at k+2. Next arbitration happens at k+3, giving a peak rate of 1 frame per 3 clocks.
- `uplink_rdy` may be high before valid; it is only sampled in SEND.
- Request deasserted between k and k+1: the frame is still latched and acked. The bus controller must not deassert before the ack.

## Configuration
- `MOPSHUB_REC_TIMEOUT_EN` defined:
  - A 1+`$clog2(TIMEOUT)`-bit counter clears on entry to SEND and increments each SEND cycle without transfer.
  - On reaching `TIMEOUT-1` without `uplink_rdy`: drop the frame, deassert valid, pulse `drop_err`, saturating-increment `drop_cnt`, go to IDLE.
  - A transfer on the same edge wins over the timeout.
- Undefined: SEND waits indefinitely; `drop_cnt` and `drop_err` are constant 0.

## Structure
- Package `mopshub_rec_arb_pkg` holds:
  - the state enum `rec_arb_state_t`
  - `FRAME_W = 76`
  - `DROP_CNT_W = 8`
- Sub-module `rr_next_index`: combinational masked round-robin finder with inputs `mask`, `last`, `n_buses` and outputs `found`, `index`. It is instantiated once.

## Test plan
- Reset, then `irq_can_rec[0]` with frame 76'h5A5 → `can_rec_select=0`, `irq_elink_rec` rises 2 clocks later, data=5A5, one `can_rec_ack[0]` pulse, `frames_sent=1`.
- Buses 3, 7, 31 request continuously, `n_buses=31`, `uplink_rdy=1` → grant order 3, 7, 31, 3, …; valid edges 3 clocks apart.
- `n_buses=4`, requests on 2 and 9 → only bus 2 served; bus 9 is never acked.
- `uplink_rdy=0` for 50 clocks with valid high → data and select stable; transfer on the first ready edge.
- Macro on, `TIMEOUT=16`, `uplink_rdy` held 0 → `drop_err` pulse after 16 SEND cycles, `drop_cnt=1`, next requester granted.
- Reset asserted in SEND → all outputs return to reset values within the reset assertion; bus 0 is granted first afterward.
